core_mem_xbar: RTL

Parametrised core-to-memory crossbar. It connects NB_MASTER core-style request ports (instruction fetch, LSU, and later DMA/debug) to NB_SLAVE single-port synchronous SRAMs. Routing uses address-range decode, with a round-robin arbiter per slave and fixed-latency response routing. It replaces the per-port protocol bridge, slice and interconnect chain with a lean request/grant fabric, and adds unmapped-address error responses, which that chain does not have.

---
 rtl/core_xbar_pkg.sv | 19 +
 rtl/core_mem_xbar_rr_arb.sv | 47 ++++
 rtl/core_mem_xbar.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/core_xbar_pkg.sv
// Shared constants and response-tracking payload for the core-to-memory crossbar.
package core_xbar_pkg;

    localparam int unsigned XBAR_DATA_WIDTH = 32;
    localparam int unsigned BE_W            = XBAR_DATA_WIDTH / 8;
    localparam logic [31:0] XBAR_ERR_RDATA  = 32'hDEAD_BEEF;

    // Index widths sized for the largest supported port count (8)
    localparam int unsigned XBAR_MAX_PORTS = 8;
    localparam int unsigned MST_IDX_W      = $clog2(XBAR_MAX_PORTS);
    localparam int unsigned SLV_IDX_W      = $clog2(XBAR_MAX_PORTS);

    typedef struct packed {
        logic                 valid;
        logic                 err;
        logic [SLV_IDX_W-1:0] sel;
    } resp_t;

endpackage

// File: rtl/core_mem_xbar_rr_arb.sv
// Round-robin arbiter: one-hot combinational grant, pointer advances past each winner.
module core_xbar_rr_arb #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_c
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] rr_q;
    logic [PTR_W-1:0] rr_d;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] idx;
    logic             found;

    // Scan from the pointer upwards, wrapping, and take the first requester
    always_comb begin
        gnt_c = '0;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PTR_W'((32'(rr_q) + i) % N);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                win        = idx;
                gnt_c[idx] = 1'b1;
            end
        end
        rr_d = rr_q;
        if (found) begin
            rr_d = (32'(win) == N - 1) ? '0 : win + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/core_mem_xbar.sv
// Core-to-SRAM crossbar: address decode, per-slave round-robin, fixed-latency responses.
// Define CORE_XBAR_RESP_REG_EN to add an output register stage on the response path.
module core_mem_xbar
    import core_xbar_pkg::*;
#(
    parameter int unsigned NB_MASTER      = 2,
    parameter int unsigned NB_SLAVE       = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 13,
    parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] START_ADDR = {32'h2000_0000, 32'h1000_0000},
    parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] END_ADDR   = {32'h2000_ffff, 32'h1000_ffff}
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NB_MASTER-1:0]                 m_req_i,
    output logic [NB_MASTER-1:0]                 m_gnt_o,
    output logic [NB_MASTER-1:0]                 m_rvalid_o,
    output logic [NB_MASTER-1:0]                 m_err_o,
    input  logic [NB_MASTER-1:0]                 m_we_i,
    input  logic [NB_MASTER*(DATA_WIDTH/8)-1:0]  m_be_i,
    input  logic [NB_MASTER*ADDR_WIDTH-1:0]      m_addr_i,
    input  logic [NB_MASTER*DATA_WIDTH-1:0]      m_wdata_i,
    output logic [NB_MASTER*DATA_WIDTH-1:0]      m_rdata_o,
    output logic [NB_SLAVE-1:0]                  mem_req_o,
    output logic [NB_SLAVE-1:0]                  mem_we_o,
    output logic [NB_SLAVE*(DATA_WIDTH/8)-1:0]   mem_be_o,
    output logic [NB_SLAVE*MEM_ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [NB_SLAVE*DATA_WIDTH-1:0]       mem_wdata_o,
    input  logic [NB_SLAVE*DATA_WIDTH-1:0]       mem_rdata_i
);

    localparam int unsigned BYTES   = DATA_WIDTH / 8;
    localparam int unsigned OFF_W   = $clog2(BYTES);
    localparam int unsigned ERR_REP = (DATA_WIDTH + 31) / 32;
    localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'({ERR_REP{XBAR_ERR_RDATA}});

    logic [NB_MASTER-1:0]      hit;
    logic [SLV_IDX_W-1:0]      sel      [NB_MASTER];
    logic [NB_MASTER-1:0]      slv_req  [NB_SLAVE];
    logic [NB_MASTER-1:0]      slv_gnt  [NB_SLAVE];
    resp_t                     resp_d   [NB_MASTER];
    resp_t                     resp_q   [NB_MASTER];
    logic [NB_MASTER-1:0]      rvalid_d;
    logic [NB_MASTER-1:0]      err_d;
    logic [NB_MASTER*DATA_WIDTH-1:0] rdata_d;

    // Region decode; scanning downwards lets the lowest matching slave win
    always_comb begin
        for (int m = 0; m < NB_MASTER; m++) begin
            hit[m] = 1'b0;
            sel[m] = '0;
            for (int s = NB_SLAVE - 1; s >= 0; s--) begin
                if ((m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] >= START_ADDR[s*ADDR_WIDTH +: ADDR_WIDTH]) &&
                    (m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] <= END_ADDR[s*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    hit[m] = 1'b1;
                    sel[m] = SLV_IDX_W'(s);
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NB_SLAVE; s++) begin
            for (int m = 0; m < NB_MASTER; m++) begin
                slv_req[s][m] = m_req_i[m] & hit[m] & (sel[m] == SLV_IDX_W'(s));
            end
        end
    end

    for (genvar s = 0; s < NB_SLAVE; s++) begin : g_arb
        core_xbar_rr_arb #(
            .N (NB_MASTER)
        ) u_arb (
            .clk   (clk),
            .rst   (rst),
            .req_i (slv_req[s]),
            .gnt_c (slv_gnt[s])
        );
    end

    // Unmapped requests are granted at once; mapped ones follow their slave's arbiter
    always_comb begin
        m_gnt_o     = m_req_i & ~hit;
        mem_req_o   = '0;
        mem_we_o    = '0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        for (int s = 0; s < NB_SLAVE; s++) begin
            for (int m = 0; m < NB_MASTER; m++) begin
                if (slv_gnt[s][m]) begin
                    m_gnt_o[m]   = 1'b1;
                    mem_req_o[s] = 1'b1;
                    mem_we_o[s]  = m_we_i[m];
                    mem_be_o[s*BYTES +: BYTES] = m_be_i[m*BYTES +: BYTES];
                    mem_addr_o[s*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH] = MEM_ADDR_WIDTH'(
                        (m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] -
                         START_ADDR[s*ADDR_WIDTH +: ADDR_WIDTH]) >> OFF_W);
                    mem_wdata_o[s*DATA_WIDTH +: DATA_WIDTH] = m_wdata_i[m*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        for (int m = 0; m < NB_MASTER; m++) begin
            resp_d[m].valid = m_gnt_o[m];
            resp_d[m].err   = ~hit[m];
            resp_d[m].sel   = sel[m];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < NB_MASTER; m++) begin
                resp_q[m] <= '0;
            end
        end else begin
            for (int m = 0; m < NB_MASTER; m++) begin
                resp_q[m] <= resp_d[m];
            end
        end
    end

    // Route the selected SRAM word (or the error pattern) back to each master
    always_comb begin
        rvalid_d = '0;
        err_d    = '0;
        rdata_d  = '0;
        for (int m = 0; m < NB_MASTER; m++) begin
            rvalid_d[m] = resp_q[m].valid;
            err_d[m]    = resp_q[m].valid & resp_q[m].err;
            if (resp_q[m].valid) begin
                if (resp_q[m].err) begin
                    rdata_d[m*DATA_WIDTH +: DATA_WIDTH] = ERR_DATA;
                end else begin
                    for (int s = 0; s < NB_SLAVE; s++) begin
                        if (resp_q[m].sel == SLV_IDX_W'(s)) begin
                            rdata_d[m*DATA_WIDTH +: DATA_WIDTH] = mem_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
            end
        end
    end

`ifdef CORE_XBAR_RESP_REG_EN
    logic [NB_MASTER-1:0]            rvalid_q;
    logic [NB_MASTER-1:0]            err_q;
    logic [NB_MASTER*DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign m_rvalid_o = rvalid_q;
    assign m_err_o    = err_q;
    assign m_rdata_o  = rdata_q;
`else
    assign m_rvalid_o = rvalid_d;
    assign m_err_o    = err_d;
    assign m_rdata_o  = rdata_d;
`endif

endmodule
